hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit (forwarding, load-use bubble, branch flush, mul/div wait FSM)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_rs1_addr/id_rs2_addr         ID-stage sources, qualified by id_uses_rs1/rs2
//   ex_rs1_addr/ex_rs2_addr         EX-stage sources (forwarding compare)
//   ex_rd_addr/ex_mem_read/ex_reg_write  EX-stage destination and control
//   mem_rd_addr/mem_reg_write       MEM-stage destination
//   wb_rd_addr/wb_reg_write         WB-stage destination
//   branch_taken                    registered branch resolution from EX
//   md_start/md_done                mul/div issue and completion
//   forward_a/forward_b             00 regfile, 01 MEM, 10 WB
//   pc_stall/ifid_stall/idex_stall  hold pipeline registers
//   ifid_flush/idex_flush/exmem_flush  insert bubbles
//   md_kill/md_busy/md_timeout      mul/div abort pulse, wait status, sticky timeout
//   stall_cycles/flush_count        32-bit event counters, present only with HAZARD_PERF_CNT_EN
//
// Build option: define HAZARD_PERF_CNT_EN to add the performance counters.
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rs1_addr,
    input  logic [4:0]  ex_rs2_addr,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_reg_write,
    input  logic        branch_taken,
    input  logic        md_start,
    input  logic        md_done,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        md_kill,
    output logic        md_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        md_timeout
);

    typedef enum logic {IDLE, MD_WAIT} state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
    logic       in_wait, load_use, timeout_hit, md_hold;
    logic       fwd_mem_a, fwd_wb_a, fwd_mem_b, fwd_wb_b;

    // ex_reg_write is part of the EX-stage control bundle but the load-use
    // check keys on ex_mem_read alone, since every load writes a register.
    logic       unused_ex_reg_write;
    assign unused_ex_reg_write = ex_reg_write;

    // Forwarding: MEM is checked first so the youngest producer wins.
    always_comb begin
        fwd_mem_a = mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == ex_rs1_addr;
        fwd_wb_a  = wb_reg_write  && wb_rd_addr  != 5'd0 && wb_rd_addr  == ex_rs1_addr;
        fwd_mem_b = mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == ex_rs2_addr;
        fwd_wb_b  = wb_reg_write  && wb_rd_addr  != 5'd0 && wb_rd_addr  == ex_rs2_addr;
        forward_a = fwd_mem_a ? 2'b01 : fwd_wb_a ? 2'b10 : 2'b00;
        forward_b = fwd_mem_b ? 2'b01 : fwd_wb_b ? 2'b10 : 2'b00;
    end

    // Hazard terms shared by the next-state and output logic. Load-use is
    // ignored while the pipe is already frozen behind a mul/div.
    always_comb begin
        in_wait     = state_q == MD_WAIT;
        load_use    = !in_wait && ex_mem_read && ex_rd_addr != 5'd0 &&
                      ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                       (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        timeout_hit = in_wait && !md_done && cnt_q == 6'(MD_TIMEOUT - 1);
        md_hold     = in_wait && !md_done;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state: a start that completes in the same cycle never waits; a
    // start killed by a taken branch stays in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        if (state_q == IDLE) begin
            if (md_start && !branch_taken && !md_done) begin
                state_d = MD_WAIT;
                cnt_d   = 6'd0;
            end
        end else begin
            cnt_d = cnt_q + 6'd1;
            if (md_done) begin
                state_d = IDLE;
            end else if (timeout_hit) begin
                state_d = IDLE;
                tmo_d   = 1'b1;
            end
        end
    end

    // Outputs: a taken branch overrides every stall. All control outputs are
    // gated by rst_n so they drop the instant reset asserts, independent of
    // the live pipeline inputs.
    always_comb begin
        pc_stall    = rst_n && !branch_taken && (load_use || md_hold);
        ifid_stall  = rst_n && !branch_taken && (load_use || md_hold);
        idex_stall  = rst_n && !branch_taken && md_hold;
        ifid_flush  = rst_n && branch_taken;
        idex_flush  = rst_n && (branch_taken || load_use);
        exmem_flush = rst_n && (branch_taken || md_hold);
        md_kill     = rst_n && ((!in_wait && md_start && branch_taken) || timeout_hit);
        md_busy     = rst_n && in_wait;
        md_timeout  = tmo_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            stall_q <= stall_q + 32'(pc_stall);
            flush_q <= flush_q + 32'(branch_taken);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule
